// File: rtl/ubuf_port_arbiter_if.sv
// rtl/ubuf_port_arbiter_if.sv - requester-side bundle of the unified-buffer port arbiter
interface ubuf_port_arbiter_if #(
    parameter int RAM_WIDTH = 128,
    parameter int ADDR_W    = 8
);
    logic                 w0_req;
    logic                 w1_req;
    logic [ADDR_W-1:0]    w0_addr;
    logic [ADDR_W-1:0]    w1_addr;
    logic [RAM_WIDTH-1:0] w0_data;
    logic [RAM_WIDTH-1:0] w1_data;
    logic                 w0_gnt;
    logic                 w1_gnt;

    logic                 r0_req;
    logic                 r1_req;
    logic [ADDR_W-1:0]    r0_addr;
    logic [ADDR_W-1:0]    r1_addr;
    logic                 r0_gnt;
    logic                 r1_gnt;
    logic                 r0_rvalid;
    logic                 r1_rvalid;
    logic [RAM_WIDTH-1:0] rd_data;

    modport master (
        output w0_req, w1_req, w0_addr, w1_addr, w0_data, w1_data,
        output r0_req, r1_req, r0_addr, r1_addr,
        input  w0_gnt, w1_gnt, r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, rd_data
    );

    modport slave (
        input  w0_req, w1_req, w0_addr, w1_addr, w0_data, w1_data,
        input  r0_req, r1_req, r0_addr, r1_addr,
        output w0_gnt, w1_gnt, r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, rd_data
    );
endinterface

// File: rtl/ubuf_port_arbiter.sv
// rtl/ubuf_port_arbiter.sv - round-robin write/read arbiter for the unified-buffer BRAM; option macro UBUF_ARB_FWD_EN
module ubuf_port_arbiter #(
    parameter int RAM_WIDTH = 128,
    parameter int RAM_DEPTH = 256,
    parameter int ADDR_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    ubuf_port_arbiter_if.slave   bus,
    output logic                 bram_wea,
    output logic [ADDR_W-1:0]    bram_addra,
    output logic [RAM_WIDTH-1:0] bram_dina,
    output logic                 bram_enb,
    output logic [ADDR_W-1:0]    bram_addrb,
    input  logic [RAM_WIDTH-1:0] bram_doutb
);

    localparam int ADDR_W_REQ = $clog2(RAM_DEPTH);

    generate
        if (ADDR_W_REQ != ADDR_W) begin : g_bad_addr_w
            $error("ubuf_port_arbiter: ADDR_W does not match RAM_DEPTH");
        end
    endgenerate

    logic                 w_prio;
    logic                 r_prio;
    logic                 w_any;
    logic                 r_any;
    logic                 w_sel;
    logic                 r_sel;
    logic                 rd_tag;
    logic [RAM_WIDTH-1:0] rd_src;

    // sel names the winning port; prio only matters when both ports request
    always_comb begin
        w_any = bus.w0_req | bus.w1_req;
        r_any = bus.r0_req | bus.r1_req;
        w_sel = (bus.w0_req & bus.w1_req) ? w_prio : bus.w1_req;
        r_sel = (bus.r0_req & bus.r1_req) ? r_prio : bus.r1_req;
    end

    assign bus.w0_gnt = ~rst & w_any & ~w_sel;
    assign bus.w1_gnt = ~rst & w_any &  w_sel;
    assign bus.r0_gnt = ~rst & r_any & ~r_sel;
    assign bus.r1_gnt = ~rst & r_any &  r_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            bram_wea   <= 1'b0;
            bram_addra <= '0;
            bram_dina  <= '0;
            w_prio     <= 1'b0;
        end else begin
            bram_wea <= w_any;
            if (w_any) begin
                bram_addra <= w_sel ? bus.w1_addr : bus.w0_addr;
                bram_dina  <= w_sel ? bus.w1_data : bus.w0_data;
            end
            if (bus.w0_req & bus.w1_req) begin
                w_prio <= ~w_sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bram_enb   <= 1'b0;
            bram_addrb <= '0;
            rd_tag     <= 1'b0;
            r_prio     <= 1'b0;
        end else begin
            bram_enb <= r_any;
            if (r_any) begin
                bram_addrb <= r_sel ? bus.r1_addr : bus.r0_addr;
                rd_tag     <= r_sel;
            end
            if (bus.r0_req & bus.r1_req) begin
                r_prio <= ~r_sel;
            end
        end
    end

    // The BRAM is read-first, so a same-cycle same-address write is only seen by forwarding
`ifdef UBUF_ARB_FWD_EN
    assign rd_src = (bram_wea && (bram_addra == bram_addrb)) ? bram_dina : bram_doutb;
`else
    assign rd_src = bram_doutb;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rd_data   <= '0;
            bus.r0_rvalid <= 1'b0;
            bus.r1_rvalid <= 1'b0;
        end else begin
            bus.r0_rvalid <= bram_enb & ~rd_tag;
            bus.r1_rvalid <= bram_enb &  rd_tag;
            if (bram_enb) begin
                bus.rd_data <= rd_src;
            end
        end
    end

endmodule

// File: tb/tb_ubuf_port_arbiter.sv
// tb/tb_ubuf_port_arbiter.sv - directed self-checking bench for ubuf_port_arbiter with a read-first BRAM model
module tb_ubuf_port_arbiter;

    localparam int RW = 128;
    localparam int AW = 8;

    logic          clk;
    logic          rst;
    logic          bram_wea;
    logic [AW-1:0] bram_addra;
    logic [RW-1:0] bram_dina;
    logic          bram_enb;
    logic [AW-1:0] bram_addrb;
    logic [RW-1:0] bram_doutb;
    logic [RW-1:0] mem [0:255];

    int checks;
    int errors;

    ubuf_port_arbiter_if #(.RAM_WIDTH(RW), .ADDR_W(AW)) bus ();

    ubuf_port_arbiter #(.RAM_WIDTH(RW), .RAM_DEPTH(256), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .bram_wea   (bram_wea),
        .bram_addra (bram_addra),
        .bram_dina  (bram_dina),
        .bram_enb   (bram_enb),
        .bram_addrb (bram_addrb),
        .bram_doutb (bram_doutb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bram_wea) mem[bram_addra] <= bram_dina;
        if (bram_enb) bram_doutb <= mem[bram_addrb];
    end

    function automatic logic [RW-1:0] dpat(input logic [7:0] a);
        return {16{a}};
    endfunction

    function automatic logic [RW-1:0] ppat(input logic [7:0] a);
        return {16{a ^ 8'h5A}};
    endfunction

    task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus.w0_req = 1'b0;
        bus.w1_req = 1'b0;
        bus.r0_req = 1'b0;
        bus.r1_req = 1'b0;
    endtask

    initial begin
        logic [RW-1:0] col_exp;
        logic [7:0]    ea;
        checks = 0;
        errors = 0;

        // reset with every requester active
        rst = 1'b1;
        bus.w0_req = 1'b1; bus.w1_req = 1'b1; bus.r0_req = 1'b1; bus.r1_req = 1'b1;
        bus.w0_addr = 8'h01; bus.w1_addr = 8'h02; bus.r0_addr = 8'h03; bus.r1_addr = 8'h04;
        bus.w0_data = dpat(8'h01); bus.w1_data = dpat(8'h02);
        tick;
        tick;
        check("rst_w0_gnt", bus.w0_gnt, 0);
        check("rst_w1_gnt", bus.w1_gnt, 0);
        check("rst_r0_gnt", bus.r0_gnt, 0);
        check("rst_r1_gnt", bus.r1_gnt, 0);
        check("rst_wea", bram_wea, 0);
        check("rst_enb", bram_enb, 0);
        check("rst_addra", bram_addra, 0);
        check("rst_addrb", bram_addrb, 0);
        check("rst_dina", bram_dina, 0);
        check("rst_rd_data", bus.rd_data, 0);
        check("rst_r0_rvalid", bus.r0_rvalid, 0);
        check("rst_r1_rvalid", bus.r1_rvalid, 0);
        rst = 1'b0;
        #1;
        check("post_rst_w0_gnt", bus.w0_gnt, 1);
        check("post_rst_w1_gnt", bus.w1_gnt, 0);
        check("post_rst_r0_gnt", bus.r0_gnt, 1);
        check("post_rst_r1_gnt", bus.r1_gnt, 0);
        idle();
        #1;
        check("idle_w0_gnt", bus.w0_gnt, 0);
        check("idle_r0_gnt", bus.r0_gnt, 0);

        // single writer then single reader of the same address
        bus.w1_req = 1'b1; bus.w1_addr = 8'h10; bus.w1_data = {16{8'hA5}};
        #1;
        check("sw_w1_gnt", bus.w1_gnt, 1);
        check("sw_w0_gnt", bus.w0_gnt, 0);
        tick;
        check("sw_wea", bram_wea, 1);
        check("sw_addra", bram_addra, 8'h10);
        check("sw_dina", bram_dina, {16{8'hA5}});
        bus.w1_req = 1'b0;
        bus.r1_req = 1'b1; bus.r1_addr = 8'h10;
        #1;
        check("sr_r1_gnt", bus.r1_gnt, 1);
        tick;
        check("sr_enb", bram_enb, 1);
        check("sr_addrb", bram_addrb, 8'h10);
        check("sr_wea_low", bram_wea, 0);
        check("sr_r1_rvalid_early", bus.r1_rvalid, 0);
        bus.r1_req = 1'b0;
        tick;
        check("sr_r1_rvalid", bus.r1_rvalid, 1);
        check("sr_r0_rvalid", bus.r0_rvalid, 0);
        check("sr_rd_data", bus.rd_data, {16{8'hA5}});
        tick;
        check("sr_r1_rvalid_pulse", bus.r1_rvalid, 0);
        check("sr_rd_data_hold", bus.rd_data, {16{8'hA5}});

        // write contention: grants alternate starting at W0
        for (int i = 0; i < 6; i++) begin
            bus.w0_req = 1'b1; bus.w1_req = 1'b1;
            bus.w0_addr = 8'h40 + 8'(i); bus.w0_data = dpat(8'h40 + 8'(i));
            bus.w1_addr = 8'h50 + 8'(i); bus.w1_data = dpat(8'h50 + 8'(i));
            #1;
            check("wc_w0_gnt", bus.w0_gnt, ((i % 2) == 0) ? 1 : 0);
            check("wc_w1_gnt", bus.w1_gnt, ((i % 2) == 1) ? 1 : 0);
            tick;
            ea = ((i % 2) == 0) ? 8'h40 + 8'(i) : 8'h50 + 8'(i);
            check("wc_addra", bram_addra, ea);
        end
        idle();
        tick;
        for (int i = 0; i < 6; i++) begin
            ea = ((i % 2) == 0) ? 8'h40 + 8'(i) : 8'h50 + 8'(i);
            check("wc_mem", mem[ea], dpat(ea));
        end

        // read contention: grants and rvalid alternate starting at R0
        for (int i = 0; i < 7; i++) begin
            if (i < 6) begin
                bus.r0_req = 1'b1; bus.r1_req = 1'b1;
                bus.r0_addr = 8'h40 + 8'(i);
                bus.r1_addr = 8'h50 + 8'(i);
                #1;
                check("rc_r0_gnt", bus.r0_gnt, ((i % 2) == 0) ? 1 : 0);
                check("rc_r1_gnt", bus.r1_gnt, ((i % 2) == 1) ? 1 : 0);
            end else begin
                idle();
            end
            tick;
            if (i >= 1) begin
                ea = (((i - 1) % 2) == 0) ? 8'h40 + 8'(i - 1) : 8'h50 + 8'(i - 1);
                check("rc_r0_rvalid", bus.r0_rvalid, (((i - 1) % 2) == 0) ? 1 : 0);
                check("rc_r1_rvalid", bus.r1_rvalid, (((i - 1) % 2) == 1) ? 1 : 0);
                check("rc_rd_data", bus.rd_data, dpat(ea));
            end
        end
        tick;
        check("rc_r0_rvalid_end", bus.r0_rvalid, 0);
        check("rc_r1_rvalid_end", bus.r1_rvalid, 0);

        // preload every address through W0
        for (int a = 0; a < 256; a++) begin
            bus.w0_req = 1'b1; bus.w0_addr = 8'(a); bus.w0_data = ppat(8'(a));
            tick;
        end
        bus.w0_req = 1'b0;

        // R1 streams all 256 addresses back to back
        for (int i = 0; i < 257; i++) begin
            if (i < 256) begin
                bus.r1_req = 1'b1; bus.r1_addr = 8'(i);
            end else begin
                bus.r1_req = 1'b0;
            end
            tick;
            if (i >= 1) begin
                check("bb_r1_rvalid", bus.r1_rvalid, 1);
                check("bb_rd_data", bus.rd_data, ppat(8'(i - 1)));
            end
        end
        tick;
        check("bb_r1_rvalid_end", bus.r1_rvalid, 0);
        check("bb_r0_rvalid_end", bus.r0_rvalid, 0);

        // same-address write/read collision
        bus.w0_req = 1'b1; bus.w0_addr = 8'h20; bus.w0_data = 128'h1111;
        tick;
        bus.w0_data = 128'h2222;
        bus.r0_req = 1'b1; bus.r0_addr = 8'h20;
        tick;
        idle();
        tick;
`ifdef UBUF_ARB_FWD_EN
        col_exp = 128'h2222;
`else
        col_exp = 128'h1111;
`endif
        check("col_r0_rvalid", bus.r0_rvalid, 1);
        check("col_rd_data", bus.rd_data, col_exp);
        bus.r0_req = 1'b1;
        tick;
        bus.r0_req = 1'b0;
        tick;
        check("col_after_rvalid", bus.r0_rvalid, 1);
        check("col_after_rd_data", bus.rd_data, 128'h2222);

        // reset while a read is in flight
        bus.r0_req = 1'b1; bus.r0_addr = 8'h20;
        tick;
        bus.r0_req = 1'b0;
        rst = 1'b1;
        tick;
        check("mr_r0_rvalid", bus.r0_rvalid, 0);
        check("mr_rd_data", bus.rd_data, 0);
        check("mr_enb", bram_enb, 0);
        rst = 1'b0;
        tick;
        check("mr_r0_rvalid_after", bus.r0_rvalid, 0);
        bus.r0_req = 1'b1; bus.r0_addr = 8'h20;
        tick;
        bus.r0_req = 1'b0;
        tick;
        check("mr_resume_rvalid", bus.r0_rvalid, 1);
        check("mr_resume_rd_data", bus.rd_data, 128'h2222);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
